// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I instruction decode stage with IF/ID register and register file
//
// Purpose:
//    Captures the fetched instruction and PC, decodes RV32I control fields and
//    the immediate, reads the 32x32 register file, and stalls fetch on a
//    load-use hazard. Consumes the EX flush (taken branch/jump).
//
// Configuration macro:
//    DECODE_WB_BYPASS_EN - when defined, a register read that hits the write-back
//                          address in the same cycle returns wb_data (write-first).
//
// Ports:
//    clk, rst            clock, asynchronous active-low reset
//    if_valid            inst_in/pc_in carry a real instruction
//    inst_in, pc_in      fetched instruction and its word-index PC
//    flush               taken branch/jump in EX: next ID is a bubble
//    ex_stall            EX cannot accept: hold every ID output
//    wb_we/addr/data     register-file write port
//    stall_if            combinational: fetch holds PC and instruction
//    id_*                registered decode results (bubble = all zero)

module decode_stage #(
   parameter int PC_WIDTH   = 32,
   parameter int INST_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_valid,
   input  logic [INST_WIDTH-1:0] inst_in,
   input  logic [PC_WIDTH-1:0]   pc_in,
   input  logic                  flush,
   input  logic                  ex_stall,
   input  logic                  wb_we,
   input  logic [4:0]            wb_addr,
   input  logic [31:0]           wb_data,
   output logic                  stall_if,
   output logic                  id_valid,
   output logic [PC_WIDTH-1:0]   id_pc,
   output logic [31:0]           rs1_data,
   output logic [31:0]           rs2_data,
   output logic [4:0]            rs1_addr,
   output logic [4:0]            rs2_addr,
   output logic [4:0]            rd_addr,
   output logic [31:0]           imm,
   output logic [3:0]            alu_op,
   output logic                  alu_src_imm,
   output logic                  alu_src_pc,
   output logic                  reg_we,
   output logic                  mem_re,
   output logic                  mem_we,
   output logic [2:0]            mem_size,
   output logic [2:0]            br_type,
   output logic                  br_en,
   output logic                  jal,
   output logic                  jalr,
   output logic                  illegal
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_SLL    = 4'd2;
   localparam logic [3:0] ALU_SLT    = 4'd3;
   localparam logic [3:0] ALU_SLTU   = 4'd4;
   localparam logic [3:0] ALU_XOR    = 4'd5;
   localparam logic [3:0] ALU_SRL    = 4'd6;
   localparam logic [3:0] ALU_SRA    = 4'd7;
   localparam logic [3:0] ALU_OR     = 4'd8;
   localparam logic [3:0] ALU_AND    = 4'd9;
   localparam logic [3:0] ALU_PASS_B = 4'd10;

   typedef struct packed {
      logic                valid;
      logic [PC_WIDTH-1:0] pc;
      logic [31:0]         rs1_data;
      logic [31:0]         rs2_data;
      logic [4:0]          rs1_addr;
      logic [4:0]          rs2_addr;
      logic [4:0]          rd_addr;
      logic [31:0]         imm;
      logic [3:0]          alu_op;
      logic                alu_src_imm;
      logic                alu_src_pc;
      logic                reg_we;
      logic                mem_re;
      logic                mem_we;
      logic [2:0]          mem_size;
      logic [2:0]          br_type;
      logic                br_en;
      logic                jal;
      logic                jalr;
      logic                illegal;
   } id_t;

   id_t         r_id;
   id_t         w_dec;
   logic [31:0] r_regs [0:31];

   logic [31:0] w_inst;
   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic [6:0]  w_funct7;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic [4:0]  w_rd;
   logic [31:0] w_imm_i;
   logic [31:0] w_imm_s;
   logic [31:0] w_imm_b;
   logic [31:0] w_imm_u;
   logic [31:0] w_imm_j;
   logic [31:0] w_rs1_rf;
   logic [31:0] w_rs2_rf;
   logic [31:0] w_rs1_rd;
   logic [31:0] w_rs2_rd;
   logic [3:0]  w_alu_base;
   logic        w_legal;
   logic        w_uses_rs1;
   logic        w_uses_rs2;
   logic        w_writes_rd;
   logic        w_load_use;

   assign w_inst   = inst_in[31:0];
   assign w_opcode = w_inst[6:0];
   assign w_rd     = w_inst[11:7];
   assign w_funct3 = w_inst[14:12];
   assign w_rs1    = w_inst[19:15];
   assign w_rs2    = w_inst[24:20];
   assign w_funct7 = w_inst[31:25];

   assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
   assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
   assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
   assign w_imm_u = {w_inst[31:12], 12'd0};
   assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

   // Register file: x0 is never written and always reads zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= '0;
         end
      end else if (wb_we && (wb_addr != 5'd0)) begin
         r_regs[wb_addr] <= wb_data;
      end
   end

   assign w_rs1_rf = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
   assign w_rs2_rf = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];

`ifdef DECODE_WB_BYPASS_EN
   assign w_rs1_rd = (wb_we && (wb_addr != 5'd0) && (wb_addr == w_rs1)) ? wb_data : w_rs1_rf;
   assign w_rs2_rd = (wb_we && (wb_addr != 5'd0) && (wb_addr == w_rs2)) ? wb_data : w_rs2_rf;
`else
   assign w_rs1_rd = w_rs1_rf;
   assign w_rs2_rd = w_rs2_rf;
`endif

   // Shared funct3 -> ALU op map for OP and OP-IMM; funct7 refines SUB/SRA.
   always_comb begin
      w_alu_base = ALU_ADD;
      case (w_funct3)
         3'b000:  w_alu_base = ALU_ADD;
         3'b001:  w_alu_base = ALU_SLL;
         3'b010:  w_alu_base = ALU_SLT;
         3'b011:  w_alu_base = ALU_SLTU;
         3'b100:  w_alu_base = ALU_XOR;
         3'b101:  w_alu_base = ALU_SRL;
         3'b110:  w_alu_base = ALU_OR;
         default: w_alu_base = ALU_AND;
      endcase
   end

   always_comb begin
      w_dec       = '0;
      w_legal     = 1'b1;
      w_uses_rs1  = 1'b0;
      w_uses_rs2  = 1'b0;
      w_writes_rd = 1'b0;
      case (w_opcode)
         OPC_LUI: begin
            w_dec.imm         = w_imm_u;
            w_dec.alu_op      = ALU_PASS_B;
            w_dec.alu_src_imm = 1'b1;
            w_writes_rd       = 1'b1;
         end
         OPC_AUIPC: begin
            w_dec.imm         = w_imm_u;
            w_dec.alu_src_imm = 1'b1;
            w_dec.alu_src_pc  = 1'b1;
            w_writes_rd       = 1'b1;
         end
         OPC_JAL: begin
            w_dec.imm        = w_imm_j;
            w_dec.alu_src_pc = 1'b1;
            w_dec.jal        = 1'b1;
            w_writes_rd      = 1'b1;
         end
         OPC_JALR: begin
            w_legal          = (w_funct3 == 3'b000);
            w_dec.imm        = w_imm_i;
            w_dec.alu_src_pc = 1'b1;
            w_dec.jalr       = 1'b1;
            w_writes_rd      = 1'b1;
            w_uses_rs1       = 1'b1;
         end
         OPC_BRANCH: begin
            w_legal       = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
            w_dec.imm     = w_imm_b;
            w_dec.alu_op  = ALU_SUB;
            w_dec.br_en   = 1'b1;
            w_dec.br_type = w_funct3;
            w_uses_rs1    = 1'b1;
            w_uses_rs2    = 1'b1;
         end
         OPC_LOAD: begin
            w_legal           = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) && (w_funct3 != 3'b111);
            w_dec.imm         = w_imm_i;
            w_dec.alu_src_imm = 1'b1;
            w_dec.mem_re      = 1'b1;
            w_dec.mem_size    = w_funct3;
            w_writes_rd       = 1'b1;
            w_uses_rs1        = 1'b1;
         end
         OPC_STORE: begin
            w_legal           = (w_funct3 <= 3'b010);
            w_dec.imm         = w_imm_s;
            w_dec.alu_src_imm = 1'b1;
            w_dec.mem_we      = 1'b1;
            w_dec.mem_size    = w_funct3;
            w_uses_rs1        = 1'b1;
            w_uses_rs2        = 1'b1;
         end
         OPC_OPIMM: begin
            w_dec.imm         = w_imm_i;
            w_dec.alu_src_imm = 1'b1;
            w_dec.alu_op      = w_alu_base;
            w_writes_rd       = 1'b1;
            w_uses_rs1        = 1'b1;
            // Shift-immediates carry a funct7 in imm[11:5]; other funct3 use it as data.
            if (w_funct3 == 3'b001) begin
               w_legal = (w_funct7 == 7'h00);
            end else if (w_funct3 == 3'b101) begin
               if (w_funct7 == 7'h20) begin
                  w_dec.alu_op = ALU_SRA;
               end else begin
                  w_legal = (w_funct7 == 7'h00);
               end
            end
         end
         OPC_OP: begin
            w_writes_rd = 1'b1;
            w_uses_rs1  = 1'b1;
            w_uses_rs2  = 1'b1;
            if (w_funct7 == 7'h00) begin
               w_dec.alu_op = w_alu_base;
            end else if ((w_funct7 == 7'h20) && (w_funct3 == 3'b000)) begin
               w_dec.alu_op = ALU_SUB;
            end else if ((w_funct7 == 7'h20) && (w_funct3 == 3'b101)) begin
               w_dec.alu_op = ALU_SRA;
            end else begin
               w_legal = 1'b0;
            end
         end
         OPC_FENCE:  w_legal = (w_funct3 <= 3'b001);
         OPC_SYSTEM: w_legal = (w_funct3 != 3'b100);
         default:    w_legal = 1'b0;
      endcase

      // An illegal instruction carries no control and uses no registers,
      // so it can neither write back nor trigger a load-use stall.
      if (!w_legal) begin
         w_dec         = '0;
         w_dec.illegal = 1'b1;
         w_uses_rs1    = 1'b0;
         w_uses_rs2    = 1'b0;
         w_writes_rd   = 1'b0;
      end

      w_dec.valid    = 1'b1;
      w_dec.pc       = pc_in;
      w_dec.rs1_data = w_rs1_rd;
      w_dec.rs2_data = w_rs2_rd;
      w_dec.rs1_addr = w_uses_rs1 ? w_rs1 : 5'd0;
      w_dec.rs2_addr = w_uses_rs2 ? w_rs2 : 5'd0;
      w_dec.rd_addr  = w_writes_rd ? w_rd : 5'd0;
      w_dec.reg_we   = w_writes_rd && (w_rd != 5'd0);
   end

   // Unused source fields decode to address 0, so they can never match a load's rd.
   assign w_load_use = r_id.valid && r_id.mem_re && (r_id.rd_addr != 5'd0) && if_valid &&
                       ((w_uses_rs1 && (w_rs1 == r_id.rd_addr)) ||
                        (w_uses_rs2 && (w_rs2 == r_id.rd_addr)));

   assign stall_if = ex_stall || w_load_use;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_id <= '0;
      end else if (flush) begin
         r_id <= '0;
      end else if (ex_stall) begin
         r_id <= r_id;
      end else if (w_load_use || !if_valid) begin
         r_id <= '0;
      end else begin
         r_id <= w_dec;
      end
   end

   assign id_valid    = r_id.valid;
   assign id_pc       = r_id.pc;
   assign rs1_data    = r_id.rs1_data;
   assign rs2_data    = r_id.rs2_data;
   assign rs1_addr    = r_id.rs1_addr;
   assign rs2_addr    = r_id.rs2_addr;
   assign rd_addr     = r_id.rd_addr;
   assign imm         = r_id.imm;
   assign alu_op      = r_id.alu_op;
   assign alu_src_imm = r_id.alu_src_imm;
   assign alu_src_pc  = r_id.alu_src_pc;
   assign reg_we      = r_id.reg_we;
   assign mem_re      = r_id.mem_re;
   assign mem_we      = r_id.mem_we;
   assign mem_size    = r_id.mem_size;
   assign br_type     = r_id.br_type;
   assign br_en       = r_id.br_en;
   assign jal         = r_id.jal;
   assign jalr        = r_id.jalr;
   assign illegal     = r_id.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage against a behavioural model
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_valid = 1'b0;
   logic [31:0] inst_in = '0;
   logic [31:0] pc_in = '0;
   logic        flush = 1'b0;
   logic        ex_stall = 1'b0;
   logic        wb_we = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;

   logic        stall_if, id_valid, alu_src_imm, alu_src_pc, reg_we, mem_re, mem_we;
   logic        br_en, jal, jalr, illegal;
   logic [31:0] id_pc, rs1_data, rs2_data, imm;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic [3:0]  alu_op;
   logic [2:0]  mem_size, br_type;

   int total = 0;
   int bad = 0;

   decode_stage #(.PC_WIDTH(32), .INST_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .inst_in(inst_in), .pc_in(pc_in),
      .flush(flush), .ex_stall(ex_stall), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .stall_if(stall_if), .id_valid(id_valid), .id_pc(id_pc), .rs1_data(rs1_data),
      .rs2_data(rs2_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
      .imm(imm), .alu_op(alu_op), .alu_src_imm(alu_src_imm), .alu_src_pc(alu_src_pc),
      .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we), .mem_size(mem_size),
      .br_type(br_type), .br_en(br_en), .jal(jal), .jalr(jalr), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [4:0]  rd_addr;
      logic [31:0] imm;
      logic [3:0]  alu_op;
      logic        alu_src_imm;
      logic        alu_src_pc;
      logic        reg_we;
      logic        mem_re;
      logic        mem_we;
      logic [2:0]  mem_size;
      logic [2:0]  br_type;
      logic        br_en;
      logic        jal;
      logic        jalr;
      logic        illegal;
   } exp_t;

   exp_t        m_out;
   logic [31:0] m_rf [0:31];

   function automatic logic [31:0] model_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
      if (wb_we && wb_addr == a) return wb_data;
`endif
      return m_rf[a];
   endfunction

   // Decode from the ISA tables; immediates built arithmetically from bit weights.
   function automatic exp_t model_decode(input logic [31:0] i, input logic [31:0] pc);
      exp_t e;
      int   tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
      int   iimm, simm, bimm, jimm;
      int   f3, f7;
      bit   ok, r1, r2, wr;
      e = '0; ok = 1; r1 = 0; r2 = 0; wr = 0;
      f3 = int'(i[14:12]);
      f7 = int'(i[31:25]);
      iimm = -2048 * int'(i[31]) + int'(i[30:20]);
      simm = -2048 * int'(i[31]) + 32 * int'(i[30:25]) + int'(i[11:7]);
      bimm = -4096 * int'(i[31]) + 2048 * int'(i[7]) + 32 * int'(i[30:25]) + 2 * int'(i[11:8]);
      jimm = -1048576 * int'(i[31]) + 4096 * int'(i[19:12]) + 2048 * int'(i[20]) + 2 * int'(i[30:21]);
      case (i[6:0])
         7'h37: begin e.imm = i & 32'hFFFFF000; e.alu_op = 10; e.alu_src_imm = 1; wr = 1; end
         7'h17: begin e.imm = i & 32'hFFFFF000; e.alu_src_imm = 1; e.alu_src_pc = 1; wr = 1; end
         7'h6F: begin e.imm = jimm; e.alu_src_pc = 1; e.jal = 1; wr = 1; end
         7'h67: begin ok = (f3 == 0); e.imm = iimm; e.alu_src_pc = 1; e.jalr = 1; wr = 1; r1 = 1; end
         7'h63: begin
            ok = (f3 != 2 && f3 != 3); e.imm = bimm; e.alu_op = 1; e.br_en = 1;
            e.br_type = i[14:12]; r1 = 1; r2 = 1;
         end
         7'h03: begin
            ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            e.imm = iimm; e.alu_src_imm = 1; e.mem_re = 1; e.mem_size = i[14:12]; wr = 1; r1 = 1;
         end
         7'h23: begin
            ok = (f3 <= 2); e.imm = simm; e.alu_src_imm = 1; e.mem_we = 1;
            e.mem_size = i[14:12]; r1 = 1; r2 = 1;
         end
         7'h13: begin
            e.imm = iimm; e.alu_src_imm = 1; wr = 1; r1 = 1; e.alu_op = 4'(tab[f3]);
            if (f3 == 1) ok = (f7 == 0);
            if (f3 == 5) begin ok = (f7 == 0 || f7 == 32); if (f7 == 32) e.alu_op = 7; end
         end
         7'h33: begin
            r1 = 1; r2 = 1; wr = 1;
            ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
            e.alu_op = 4'(tab[f3]);
            if (f7 == 32) e.alu_op = (f3 == 0) ? 4'd1 : 4'd7;
         end
         7'h0F: ok = (f3 <= 1);
         7'h73: ok = (f3 != 4);
         default: ok = 0;
      endcase
      if (!ok) begin
         e = '0; e.illegal = 1; r1 = 0; r2 = 0; wr = 0;
      end
      e.valid    = 1;
      e.pc       = pc;
      e.rs1_data = model_read(i[19:15]);
      e.rs2_data = model_read(i[24:20]);
      e.rs1_addr = r1 ? i[19:15] : 5'd0;
      e.rs2_addr = r2 ? i[24:20] : 5'd0;
      e.rd_addr  = wr ? i[11:7] : 5'd0;
      e.reg_we   = wr && (i[11:7] != 0);
      return e;
   endfunction

   function automatic bit model_load_use();
      exp_t d;
      d = model_decode(inst_in, pc_in);
      return m_out.valid && m_out.mem_re && (m_out.rd_addr != 0) && if_valid &&
             ((d.rs1_addr == m_out.rd_addr) || (d.rs2_addr == m_out.rd_addr));
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_out <= '0;
         for (int k = 0; k < 32; k++) m_rf[k] <= '0;
      end else begin
         if (flush) m_out <= '0;
         else if (ex_stall) m_out <= m_out;
         else if (model_load_use() || !if_valid) m_out <= '0;
         else m_out <= model_decode(inst_in, pc_in);
         if (wb_we && wb_addr != 0) m_rf[wb_addr] <= wb_data;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
      end
   endtask

   task automatic compare_outputs();
      chk("id_valid", 32'(id_valid), 32'(m_out.valid));
      chk("id_pc", id_pc, m_out.pc);
      chk("rs1_data", rs1_data, m_out.rs1_data);
      chk("rs2_data", rs2_data, m_out.rs2_data);
      chk("rs1_addr", 32'(rs1_addr), 32'(m_out.rs1_addr));
      chk("rs2_addr", 32'(rs2_addr), 32'(m_out.rs2_addr));
      chk("rd_addr", 32'(rd_addr), 32'(m_out.rd_addr));
      chk("imm", imm, m_out.imm);
      chk("alu_op", 32'(alu_op), 32'(m_out.alu_op));
      chk("alu_src_imm", 32'(alu_src_imm), 32'(m_out.alu_src_imm));
      chk("alu_src_pc", 32'(alu_src_pc), 32'(m_out.alu_src_pc));
      chk("reg_we", 32'(reg_we), 32'(m_out.reg_we));
      chk("mem_re", 32'(mem_re), 32'(m_out.mem_re));
      chk("mem_we", 32'(mem_we), 32'(m_out.mem_we));
      chk("mem_size", 32'(mem_size), 32'(m_out.mem_size));
      chk("br_type", 32'(br_type), 32'(m_out.br_type));
      chk("br_en", 32'(br_en), 32'(m_out.br_en));
      chk("jal", 32'(jal), 32'(m_out.jal));
      chk("jalr", 32'(jalr), 32'(m_out.jalr));
      chk("illegal", 32'(illegal), 32'(m_out.illegal));
   endtask

   // Check the combinational stall against the inputs now applied, clock, then check registers.
   task automatic cyc();
      #1;
      chk("stall_if", 32'(stall_if), 32'(ex_stall || model_load_use()));
      @(posedge clk);
      #1;
      compare_outputs();
   endtask

   function automatic logic [31:0] rand_inst();
      logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                                7'h13, 7'h33, 7'h0F, 7'h73};
      logic [31:0] r;
      int          sel;
      r = $urandom;
      sel = $urandom_range(0, 11);
      r[6:0]   = (sel == 11) ? 7'($urandom) : ops[sel];
      r[11:7]  = 5'($urandom_range(0, 7));
      r[19:15] = 5'($urandom_range(0, 7));
      r[24:20] = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
         0: r[31:25] = 7'h00;
         1: r[31:25] = 7'h20;
         default: ;
      endcase
      return r;
   endfunction

   logic held;

   initial begin
      rst = 1'b0;
      repeat (3) cyc();
      chk("reset_id_valid", 32'(id_valid), 32'd0);
      chk("reset_reg_we", 32'(reg_we), 32'd0);
      rst = 1'b1;

      // addi x1,x0,5 at pc 4
      if_valid = 1'b1; inst_in = 32'h00500093; pc_in = 32'd4;
      cyc();
      chk("addi_valid", 32'(id_valid), 32'd1);
      chk("addi_pc", id_pc, 32'd4);
      chk("addi_rd", 32'(rd_addr), 32'd1);
      chk("addi_imm", imm, 32'd5);
      chk("addi_alu_op", 32'(alu_op), 32'd0);
      chk("addi_src_imm", 32'(alu_src_imm), 32'd1);
      chk("addi_reg_we", 32'(reg_we), 32'd1);

      // lw x5,0(x2) followed by add x6,x5,x1
      inst_in = 32'h00012283; pc_in = 32'd5;
      cyc();
      inst_in = 32'h00128333; pc_in = 32'd6;
      #1 chk("lu_stall", 32'(stall_if), 32'd1);
      cyc();
      chk("lu_bubble", 32'(id_valid), 32'd0);
      #1 chk("lu_release", 32'(stall_if), 32'd0);
      cyc();
      chk("lu_add_valid", 32'(id_valid), 32'd1);
      chk("lu_add_rd", 32'(rd_addr), 32'd6);
      chk("lu_add_rs1", 32'(rs1_addr), 32'd5);

      // flush wins over ex_stall
      inst_in = 32'h00012283; pc_in = 32'd7; flush = 1'b1; ex_stall = 1'b1;
      cyc();
      chk("flush_valid", 32'(id_valid), 32'd0);
      chk("flush_reg_we", 32'(reg_we), 32'd0);
      chk("flush_mem_we", 32'(mem_we), 32'd0);
      flush = 1'b0; ex_stall = 1'b0;

      // write-back same-cycle read of x3
      if_valid = 1'b0; wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h1234;
      cyc();
      wb_data = 32'hDEAD; if_valid = 1'b1; inst_in = 32'h00018213; pc_in = 32'd8;
      cyc();
`ifdef DECODE_WB_BYPASS_EN
      chk("wb_bypass", rs1_data, 32'hDEAD);
`else
      chk("wb_nobypass", rs1_data, 32'h1234);
`endif
      wb_we = 1'b0;
      cyc();
      chk("wb_after", rs1_data, 32'hDEAD);

      // write to x0 is dropped
      if_valid = 1'b0; wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
      cyc();
      if_valid = 1'b1; inst_in = 32'h00000093;
      cyc();
      chk("x0_read", rs1_data, 32'd0);
      wb_we = 1'b0;

      // undefined opcode
      inst_in = 32'h0000007F;
      cyc();
      chk("ill_flag", 32'(illegal), 32'd1);
      chk("ill_reg_we", 32'(reg_we), 32'd0);
      chk("ill_valid", 32'(id_valid), 32'd1);

      // ex_stall holds outputs
      inst_in = 32'h00500093; pc_in = 32'd9;
      cyc();
      ex_stall = 1'b1; inst_in = 32'h0000007F; pc_in = 32'd10;
      #1 chk("exs_stall", 32'(stall_if), 32'd1);
      cyc();
      chk("exs_hold_pc", id_pc, 32'd9);
      chk("exs_hold_ill", 32'(illegal), 32'd0);
      ex_stall = 1'b0;

      // randomized traffic; upstream holds its instruction while stalled
      held = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if (!held) begin
            if_valid = ($urandom_range(0, 7) != 0);
            inst_in  = rand_inst();
            pc_in    = pc_in + 32'd1;
         end
         flush    = ($urandom_range(0, 15) == 0);
         ex_stall = ($urandom_range(0, 4) == 0);
         wb_we    = $urandom_range(0, 1) == 1;
         wb_addr  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         wb_data  = $urandom;
         #1 held = stall_if && !flush;
         cyc();
      end

      // asynchronous reset mid-run
      flush = 1'b0; ex_stall = 1'b0; wb_we = 1'b0;
      if_valid = 1'b1; inst_in = 32'h00500093;
      #2 rst = 1'b0;
      #1;
      chk("arst_valid", 32'(id_valid), 32'd0);
      chk("arst_reg_we", 32'(reg_we), 32'd0);
      chk("arst_imm", imm, 32'd0);
      compare_outputs();
      @(posedge clk);
      #1 rst = 1'b1;

      for (int k = 1; k < 32; k++) begin
         inst_in = (32'(k) << 20) | (32'(k) << 15) | 32'h00000093;
         pc_in   = 32'(100 + k);
         cyc();
         chk("arst_rs1_zero", rs1_data, 32'd0);
         chk("arst_rs2_zero", rs2_data, 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
